// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: opcode encoding and datapath width.
package alu_pkg;

  localparam int unsigned W = 8;

  typedef enum logic [2:0] {
    kADD = 3'b000,
    kAND = 3'b001,
    kXOR = 3'b010,
    kLSH = 3'b011,
    kSTR = 3'b100,
    kLDI = 3'b101,
    kBNE = 3'b110
  } op_t;

  // Only arithmetic/logic/branch ops update the status flags; moves and reserved codes hold them.
  function automatic logic op_updates_flags(op_t op);
    return (op == kADD) || (op == kAND) || (op == kXOR) || (op == kLSH) || (op == kBNE);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical shifter; co is the last bit shifted out, zero for n=0 and n>=9.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [W-1:0] in_i,
  input  logic [3:0]   n_i,
  input  logic         rsh_i,
  output logic [W-1:0] out_o,
  output logic         co_o
);

  logic [W:0] left_ext;
  logic [W:0] right_ext;

  // A guard bit beside the operand catches the final bit shifted out; n>=9 clears it naturally.
  assign left_ext  = {1'b0, in_i} << n_i;
  assign right_ext = {in_i, 1'b0} >> n_i;

  always_comb begin
    out_o = '0;
    co_o  = 1'b0;
    if (rsh_i) begin
      out_o = right_ext[W:1];
      co_o  = right_ext[0];
    end else begin
      out_o = left_ext[W-1:0];
      co_o  = left_ext[W];
    end
  end

endmodule

// File: rtl/alu.sv
// 8-bit ALU: combinational result/carry/zero plus registered carry and zero status flags.
module alu
  import alu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         rsh_i,
  input  logic         ci_i,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] in_a_i,
  input  logic [W-1:0] in_b_i,
  output logic [W-1:0] rslt_o,
  output logic         co_o,
  output logic         z_o,
  output logic         flag_c_o,
  output logic         flag_z_o
);

  op_t        op;
  logic [W:0] sum;
  logic [W-1:0] shift_out;
  logic       shift_co;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;

  assign op  = op_t'(op_i);
  assign sum = {1'b0, in_a_i} + {1'b0, in_b_i} + {{W{1'b0}}, ci_i};

  alu_shifter u_shifter (
    .in_i  (in_a_i),
    .n_i   (in_b_i[3:0]),
    .rsh_i (rsh_i),
    .out_o (shift_out),
    .co_o  (shift_co)
  );

  always_comb begin
    rslt_o = '0;
    co_o   = 1'b0;
    z_o    = 1'b0;
    case (op)
      kADD: begin
        rslt_o = sum[W-1:0];
        co_o   = sum[W];
      end
      kAND: rslt_o = in_a_i & in_b_i;
      kXOR: rslt_o = in_a_i ^ in_b_i;
      kLSH: begin
        rslt_o = shift_out;
        co_o   = shift_co;
      end
      kSTR: rslt_o = in_a_i;
      kLDI: rslt_o = in_b_i;
      kBNE: rslt_o = in_a_i ^ in_b_i;
      default: rslt_o = '0;
    endcase
    // Reserved encoding is not an ALU op, so it never reports zero.
    if (op_i != 3'b111) begin
      z_o = (rslt_o == '0);
    end
  end

  always_comb begin
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (op_updates_flags(op)) begin
      flag_c_d = co_o;
      flag_z_d = z_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign flag_c_o = flag_c_q;
  assign flag_z_o = flag_z_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU: combinational results per opcode and flag register behaviour.
module tb_alu;

  logic       clk;
  logic       rst;
  logic       rsh;
  logic       ci;
  logic [2:0] op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] rslt;
  logic       co;
  logic       z;
  logic       flag_c;
  logic       flag_z;

  int unsigned n_tests;
  int unsigned n_fail;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpAnd = 3'b001;
  localparam logic [2:0] OpXor = 3'b010;
  localparam logic [2:0] OpLsh = 3'b011;
  localparam logic [2:0] OpStr = 3'b100;
  localparam logic [2:0] OpLdi = 3'b101;
  localparam logic [2:0] OpBne = 3'b110;
  localparam logic [2:0] OpRsv = 3'b111;

  alu dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .rsh_i    (rsh),
    .ci_i     (ci),
    .op_i     (op),
    .in_a_i   (in_a),
    .in_b_i   (in_b),
    .rslt_o   (rslt),
    .co_o     (co),
    .z_o      (z),
    .flag_c_o (flag_c),
    .flag_z_o (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one vector after the falling edge and checks {rslt, co, z} packed together.
  task automatic apply(input string tag, input logic [2:0] o, input logic r, input logic c,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_r, input logic exp_co, input logic exp_z);
    @(negedge clk);
    op = o; rsh = r; ci = c; in_a = a; in_b = b;
    #1;
    check_eq(tag, {6'd0, rslt, co, z}, {6'd0, exp_r, exp_co, exp_z});
  endtask

  task automatic check_flags(input string tag, input logic exp_c, input logic exp_z);
    check_eq(tag, {14'd0, flag_c, flag_z}, {14'd0, exp_c, exp_z});
  endtask

  // Sets up an op, lets one rising edge pass, then samples the flags just after it.
  task automatic clock_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op = o; rsh = 1'b0; ci = 1'b0; in_a = a; in_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; rsh = 1'b0; ci = 1'b0; op = OpAdd; in_a = 8'hFF; in_b = 8'h04;
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset_flags", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    apply("add_23_22",   OpAdd, 1'b0, 1'b0, 8'd23,  8'd22,  8'd45,  1'b0, 1'b0);
    apply("add_5_fe",    OpAdd, 1'b0, 1'b0, 8'd5,   8'hFE,  8'd3,   1'b1, 1'b0);
    apply("add_255_4",   OpAdd, 1'b1, 1'b0, 8'd255, 8'd4,   8'd3,   1'b1, 1'b0);
    apply("add_255_ci",  OpAdd, 1'b0, 1'b1, 8'd255, 8'd0,   8'd0,   1'b1, 1'b1);
    apply("and_ff_0",    OpAnd, 1'b0, 1'b1, 8'hFF,  8'h00,  8'h00,  1'b0, 1'b1);
    apply("and_55_aa",   OpAnd, 1'b0, 1'b0, 8'h55,  8'hAA,  8'h00,  1'b0, 1'b1);
    apply("and_55_55",   OpAnd, 1'b0, 1'b0, 8'h55,  8'h55,  8'h55,  1'b0, 1'b0);
    apply("xor_55_55",   OpXor, 1'b0, 1'b0, 8'h55,  8'h55,  8'h00,  1'b0, 1'b1);
    apply("xor_55_0",    OpXor, 1'b1, 1'b1, 8'h55,  8'h00,  8'h55,  1'b0, 1'b0);
    apply("lsh_16_l2",   OpLsh, 1'b0, 1'b0, 8'd16,  8'd2,   8'd64,  1'b0, 1'b0);
    apply("lsh_16_r2",   OpLsh, 1'b1, 1'b0, 8'd16,  8'd2,   8'd4,   1'b0, 1'b0);
    apply("lsh_81_l1",   OpLsh, 1'b0, 1'b0, 8'h81,  8'd1,   8'h02,  1'b1, 1'b0);
    apply("lsh_81_r1",   OpLsh, 1'b1, 1'b0, 8'h81,  8'd1,   8'h40,  1'b1, 1'b0);
    apply("lsh_81_n0",   OpLsh, 1'b0, 1'b1, 8'h81,  8'd0,   8'h81,  1'b0, 1'b0);
    apply("lsh_81_l8",   OpLsh, 1'b0, 1'b0, 8'h81,  8'd8,   8'h00,  1'b1, 1'b1);
    apply("lsh_81_r8",   OpLsh, 1'b1, 1'b0, 8'h81,  8'd8,   8'h00,  1'b1, 1'b1);
    apply("lsh_81_l9",   OpLsh, 1'b0, 1'b0, 8'h81,  8'd9,   8'h00,  1'b0, 1'b1);
    apply("lsh_81_r15",  OpLsh, 1'b1, 1'b0, 8'h81,  8'd15,  8'h00,  1'b0, 1'b1);
    apply("lsh_84_hi_r3",OpLsh, 1'b1, 1'b0, 8'h84,  8'hF3,  8'h10,  1'b1, 1'b0);
    apply("lsh_81_hi_l3",OpLsh, 1'b0, 1'b0, 8'h81,  8'hF3,  8'h08,  1'b0, 1'b0);
    apply("str_16_2",    OpStr, 1'b0, 1'b1, 8'd16,  8'd2,   8'd16,  1'b0, 1'b0);
    apply("str_0_5",     OpStr, 1'b0, 1'b0, 8'd0,   8'd5,   8'd0,   1'b0, 1'b1);
    apply("ldi_16_63",   OpLdi, 1'b0, 1'b0, 8'd16,  8'd63,  8'd63,  1'b0, 1'b0);
    apply("bne_56_56",   OpBne, 1'b0, 1'b0, 8'd56,  8'd56,  8'd0,   1'b0, 1'b1);
    apply("bne_58_56",   OpBne, 1'b0, 1'b0, 8'd58,  8'd56,  8'd2,   1'b0, 1'b0);
    apply("reserved",    OpRsv, 1'b1, 1'b1, 8'd5,   8'd5,   8'd0,   1'b0, 1'b0);

    clock_op(OpAdd, 8'd255, 8'd4);
    check_flags("flag_add_carry", 1'b1, 1'b0);
    clock_op(OpLdi, 8'd0, 8'd0);
    check_flags("flag_ldi_hold", 1'b1, 1'b0);
    clock_op(OpBne, 8'd56, 8'd56);
    check_flags("flag_bne_eq", 1'b0, 1'b1);
    clock_op(OpStr, 8'd7, 8'd0);
    check_flags("flag_str_hold", 1'b0, 1'b1);
    clock_op(OpRsv, 8'd1, 8'd2);
    check_flags("flag_rsv_hold", 1'b0, 1'b1);
    clock_op(OpAnd, 8'h55, 8'h55);
    check_flags("flag_and_nz", 1'b0, 1'b0);
    clock_op(OpAdd, 8'd255, 8'd4);
    check_flags("flag_add_again", 1'b1, 1'b0);

    // Asynchronous reset in the middle of the high phase, away from any edge.
    #2;
    rst = 1'b1;
    #1;
    check_flags("flag_async_rst", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_flags("flag_rst_held", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_flags("flag_rst_release", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_flags("flag_first_update", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
